scmp_alu_seq: RTL and testbench

- Parametrised, sequenced successor to the SC/MP combinational ALU.
- Adds:
  - configurable datapath width
  - a real nibble-serial decimal add (DAD)
  - multi-bit rotate through carry
  - proper signed overflow
  - a start/done handshake with registered results
- Sits between the microcode sequencer and the register file. The sequencer holds off on `busy` until `done` pulses.

---
 rtl/scmp_alu_pkg.sv | 24 ++
 rtl/scmp_bcd_nibble_add.sv | 25 ++
 rtl/scmp_alu_seq.sv | 160 ++++++++++++++++
 tb/tb_scmp_alu_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/scmp_alu_pkg.sv
// Shared types and constants for the sequenced SC/MP ALU.
package scmp_alu_pkg;

   typedef enum logic [3:0] {
      OP_PASS = 4'd0,
      OP_AND  = 4'd1,
      OP_OR   = 4'd2,
      OP_XOR  = 4'd3,
      OP_ADD  = 4'd4,
      OP_DAD  = 4'd5,
      OP_RRL  = 4'd6,
      OP_INC  = 4'd7,
      OP_DEC  = 4'd8
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } alu_state_t;

   localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/scmp_bcd_nibble_add.sv
// Combinational single-digit BCD adder; results above 9 are corrected by +6 with carry out.
module scmp_bcd_nibble_add
   import scmp_alu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] raw;

   always_comb begin
      raw = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      s   = raw[3:0];
      co  = 1'b0;
      // Non-BCD digits go through the same rule; the 4-bit wrap gives the corrected digit.
      if (raw > 5'd9) begin
         s  = raw[3:0] + BCD_ADJ;
         co = 1'b1;
      end
   end

endmodule

// File: rtl/scmp_alu_seq.sv
// Sequenced SC/MP ALU: done at accept+1+N (N=1; WIDTH/4 for DAD; max(cnt,1) for RRL); busy until done,
// start ignored while busy except in the done cycle. Nibble-serial DAD only when SCMP_ALU_DAD_EN is defined.
module scmp_alu_seq
   import scmp_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  alu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CNT_W-1:0] cnt,
   input  logic             cy_i,
   input  logic             ov_i,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             cy_o,
   output logic             ov_o
);

   alu_state_t       state, state_nxt;
   alu_op_t          op_q, op_dec;
   logic [WIDTH-1:0] acc, bq, res_q;
   logic             cq, oq, cy_q, ov_q, rot_en;
   logic [CNT_W-1:0] step, steps_ld;
   logic             accept, commit, last_step;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cy, alu_ov;
   logic [WIDTH:0]   add_sum, inc_sum;

`ifdef SCMP_ALU_DAD_EN
   localparam logic [CNT_W-1:0] DAD_STEPS = CNT_W'(WIDTH / 4);
   logic [3:0] dig;
   logic       dco;

   scmp_bcd_nibble_add u_nib (
      .a  (acc[3:0]),
      .b  (bq[3:0]),
      .ci (cq),
      .s  (dig),
      .co (dco)
   );
`endif

   assign commit    = (state == DONE) && !flush;
   assign accept    = start && !flush && ((state == IDLE) || commit);
   assign last_step = (step == CNT_W'(1));
   assign busy      = (state != IDLE);
   assign done      = commit;
   // The done cycle already shows the new result; the held copy is taken at the same time.
   assign res       = commit ? acc : res_q;
   assign cy_o      = commit ? cq  : cy_q;
   assign ov_o      = commit ? oq  : ov_q;

   always_comb begin
      op_dec = op;
`ifndef SCMP_ALU_DAD_EN
      if (op == OP_DAD) op_dec = OP_ADD;
`endif
      steps_ld = CNT_W'(1);
      case (op_dec)
         OP_RRL:  if (cnt != '0) steps_ld = cnt;
`ifdef SCMP_ALU_DAD_EN
         OP_DAD:  steps_ld = DAD_STEPS;
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    if (flush) state_nxt = IDLE;
                  else if (last_step) state_nxt = DONE;
         DONE:    state_nxt = accept ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      add_sum = {1'b0, acc} + {1'b0, bq} + {{WIDTH{1'b0}}, cq};
      inc_sum = {1'b0, acc} + (WIDTH+1)'(1);
      alu_res = acc;
      alu_cy  = cq;
      alu_ov  = oq;
      case (op_q)
         OP_AND: alu_res = acc & bq;
         OP_OR:  alu_res = acc | bq;
         OP_XOR: alu_res = acc ^ bq;
         OP_ADD: begin
            {alu_cy, alu_res} = add_sum;
            alu_ov = (acc[WIDTH-1] == bq[WIDTH-1]) && (add_sum[WIDTH-1] != acc[WIDTH-1]);
         end
`ifdef SCMP_ALU_DAD_EN
         OP_DAD: begin
            alu_res = {dig, acc[WIDTH-1:4]};
            alu_cy  = dco;
         end
`endif
         OP_RRL: if (rot_en) {alu_cy, alu_res} = {acc[0], cq, acc[WIDTH-1:1]};
         OP_INC: {alu_cy, alu_res} = inc_sum;
         OP_DEC: begin
            alu_res = acc - WIDTH'(1);
            alu_cy  = (acc == '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_PASS;
         acc    <= '0;
         bq     <= '0;
         cq     <= 1'b0;
         oq     <= 1'b0;
         rot_en <= 1'b0;
         step   <= '0;
      end else if (accept) begin
         op_q   <= op_dec;
         acc    <= a;
         bq     <= b;
         cq     <= cy_i;
         oq     <= ov_i;
         rot_en <= (cnt != '0);
         step   <= steps_ld;
      end else if (state == EXEC) begin
         // acc doubles as the shift register: DAD and RRL consume it low end first.
         acc  <= alu_res;
         cq   <= alu_cy;
         oq   <= alu_ov;
         bq   <= bq >> 4;
         step <= step - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= '0;
         cy_q  <= 1'b0;
         ov_q  <= 1'b0;
      end else if (commit) begin
         res_q <= acc;
         cy_q  <= cq;
         ov_q  <= oq;
      end
   end

endmodule

// File: tb/tb_scmp_alu_seq.sv
// Directed self-checking bench for scmp_alu_seq at WIDTH=8, CNT_W=3.
module tb_scmp_alu_seq;
   import scmp_alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start, cy_i, ov_i, flush;
   alu_op_t    op;
   logic [7:0] a, b;
   logic [2:0] cnt;
   logic       busy, done, cy_o, ov_o;
   logic [7:0] res;

   int checks = 0;
   int errors = 0;
   int ndone;

   scmp_alu_seq #(.WIDTH(8), .CNT_W(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .cnt   (cnt),
      .cy_i  (cy_i),
      .ov_i  (ov_i),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .res   (res),
      .cy_o  (cy_o),
      .ov_o  (ov_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input bit b2b, input alu_op_t o, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [2:0] ic, input logic icy, input logic iov, input int elat,
                        input logic [7:0] er, input logic ecy, input logic eov, input string tag);
      int lat;
      if (!b2b) @(negedge clk);
      start = 1'b1; op = o; a = ia; b = ib; cnt = ic; cy_i = icy; ov_i = iov;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
         if (done) begin
            lat = k;
            break;
         end
      end
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      chk({tag, "_res"}, 32'(res), 32'(er));
      chk({tag, "_cy"},  32'(cy_o), 32'(ecy));
      chk({tag, "_ov"},  32'(ov_o), 32'(eov));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_PASS;
      a = '0; b = '0; cnt = '0; cy_i = 1'b0; ov_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res",  32'(res),  32'd0);
      chk("rst_cyov", 32'({cy_o, ov_o}), 32'd0);
      rst = 1'b0;

      do_op(1'b0, OP_ADD, 8'h7F, 8'h01, 3'd0, 1'b0, 1'b0, 2, 8'h80, 1'b0, 1'b1, "add_ov");
      do_op(1'b0, OP_ADD, 8'hFF, 8'h01, 3'd0, 1'b0, 1'b1, 2, 8'h00, 1'b1, 1'b0, "add_cy");
`ifdef SCMP_ALU_DAD_EN
      do_op(1'b0, OP_DAD, 8'h59, 8'h48, 3'd0, 1'b0, 1'b0, 3, 8'h07, 1'b1, 1'b0, "dad");
`else
      do_op(1'b0, OP_DAD, 8'h59, 8'h48, 3'd0, 1'b0, 1'b0, 2, 8'hA1, 1'b0, 1'b1, "dad");
`endif
      do_op(1'b0, OP_RRL, 8'h81, 8'h00, 3'd3, 1'b0, 1'b1, 4, 8'h50, 1'b0, 1'b1, "rrl3");
      do_op(1'b0, OP_RRL, 8'h81, 8'h00, 3'd0, 1'b0, 1'b0, 2, 8'h81, 1'b0, 1'b0, "rrl0");
      do_op(1'b0, OP_RRL, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0, 8, 8'h04, 1'b0, 1'b0, "rrl7");
      do_op(1'b0, OP_RRL, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0, 2, 8'h80, 1'b0, 1'b0, "rrl1");
      do_op(1'b0, OP_INC, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 2, 8'h00, 1'b1, 1'b0, "inc_ff");
      do_op(1'b0, OP_INC, 8'h41, 8'h00, 3'd0, 1'b1, 1'b1, 2, 8'h42, 1'b0, 1'b1, "inc_41");
      do_op(1'b0, OP_DEC, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 2, 8'hFF, 1'b1, 1'b0, "dec_00");
      do_op(1'b0, OP_DEC, 8'h01, 8'h00, 3'd0, 1'b1, 1'b0, 2, 8'h00, 1'b0, 1'b0, "dec_01");
      do_op(1'b0, OP_AND, 8'hF0, 8'h3C, 3'd0, 1'b1, 1'b1, 2, 8'h30, 1'b1, 1'b1, "and");
      do_op(1'b0, OP_OR,  8'hF0, 8'h3C, 3'd0, 1'b0, 1'b1, 2, 8'hFC, 1'b0, 1'b1, "or");
      do_op(1'b0, OP_XOR, 8'hF0, 8'h3C, 3'd0, 1'b1, 1'b0, 2, 8'hCC, 1'b1, 1'b0, "xor");
      do_op(1'b0, alu_op_t'(4'd12), 8'hC3, 8'h3C, 3'd0, 1'b0, 1'b1, 2, 8'hC3, 1'b0, 1'b1, "undef");

      // Back-to-back: second start driven in the done cycle of the first.
      do_op(1'b0, OP_ADD, 8'h10, 8'h22, 3'd0, 1'b0, 1'b0, 2, 8'h32, 1'b0, 1'b0, "b2b_first");
      do_op(1'b1, OP_INC, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1, 2, 8'h00, 1'b1, 1'b1, "b2b_second");

      // Flush during EXEC of a DAD: no done and the previous result stays.
      do_op(1'b0, OP_PASS, 8'h5A, 8'h00, 3'd0, 1'b1, 1'b0, 2, 8'h5A, 1'b1, 1'b0, "pass");
      @(negedge clk);
      start = 1'b1; op = OP_DAD; a = 8'h99; b = 8'h99; cy_i = 1'b0; ov_i = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("flush_no_done", 32'(ndone), 32'd0);
      chk("flush_res",     32'(res),   32'h5A);
      chk("flush_cyov",    32'({cy_o, ov_o}), 32'b10);
      chk("flush_busy",    32'(busy),  32'd0);

      // start held high during busy must not produce a second accept.
      @(negedge clk);
      start = 1'b1; op = OP_RRL; a = 8'h81; b = 8'h00; cnt = 3'd3; cy_i = 1'b0; ov_i = 1'b0;
      @(posedge clk);
      #1 op = OP_ADD; a = 8'h01; b = 8'h01; cnt = 3'd0;
      for (int k = 0; k < 3; k++) @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_res",  32'(res),  32'h50);
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("hold_no_second", 32'(ndone), 32'd0);
      chk("hold_idle_busy", 32'(busy),  32'd0);

      // Asynchronous reset in the middle of a long RRL.
      do_op(1'b0, OP_AND, 8'hFF, 8'hA5, 3'd0, 1'b1, 1'b1, 2, 8'hA5, 1'b1, 1'b1, "pre_rst");
      @(negedge clk);
      start = 1'b1; op = OP_RRL; a = 8'h81; cnt = 3'd7; cy_i = 1'b1; ov_i = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_res",  32'(res),  32'd0);
      chk("arst_cyov", 32'({cy_o, ov_o}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_op(1'b0, OP_ADD, 8'h12, 8'h34, 3'd0, 1'b1, 1'b0, 2, 8'h47, 1'b0, 1'b0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
